// File: rtl/board_io_ctrl.sv
// Board IO stage: registered 24-bit LEDs written by stores, and synchronised,
// debounced 24-bit DIP switches returned on loads. Optional macro
// BOARD_IO_CHANGE_FLAG_EN adds a sticky "switches changed" flag to the high-half read.
module board_io_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000,
  parameter int          SW_WIDTH        = 24
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_read,
  input  logic                io_write,
  input  logic                led_ctrl,
  input  logic                switch_ctrl,
  input  logic [1:0]          addr_low,
  input  logic [31:0]         io_wdata,
  input  logic [SW_WIDTH-1:0] switch_in,
  output logic [15:0]         io_rdata,
  output logic [SW_WIDTH-1:0] led_out
);

  logic [SW_WIDTH-1:0] sync1, sync2;
  logic [SW_WIDTH-1:0] candidate, candidate_next;
  logic [SW_WIDTH-1:0] debounced, debounced_next;
  logic [15:0]         counter, counter_next;
  logic                flag_bit;
  logic                hi_read;

  // Byte-address bit 0 and the upper store half have no meaning here.
  logic unused_bits;
  assign unused_bits = ^{addr_low[0], io_wdata[31:16]};

  assign hi_read = io_read && switch_ctrl && addr_low[1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would collapse the two-flop synchroniser.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else if (io_write && led_ctrl) begin
      if (addr_low[1]) led_out[23:16] <= io_wdata[7:0];
      else             led_out[15:0]  <= io_wdata[15:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      candidate <= '0;
      counter   <= '0;
      debounced <= '0;
    end else begin
      sync1     <= switch_in;
      sync2     <= sync1;
      candidate <= candidate_next;
      counter   <= counter_next;
      debounced <= debounced_next;
    end
  end

  // Any disagreement restarts the count; once saturated the candidate is published.
  always_comb begin
    candidate_next = candidate;
    counter_next   = counter;
    debounced_next = debounced;
    if (sync2 != candidate) begin
      candidate_next = sync2;
      counter_next   = '0;
    end else if (counter == DEBOUNCE_CYCLES - 16'd1) begin
      debounced_next = candidate;
    end else begin
      counter_next = counter + 16'd1;
    end
  end

`ifdef BOARD_IO_CHANGE_FLAG_EN
  logic change_flag;

  // A fresh change outranks the clear from a coincident high-half read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             change_flag <= 1'b0;
    else if (debounced_next != debounced)  change_flag <= 1'b1;
    else if (hi_read)                      change_flag <= 1'b0;
  end

  assign flag_bit = change_flag;
`else
  assign flag_bit = 1'b0;
`endif

  always_comb begin
    io_rdata = 16'h0000;
    if (io_read && switch_ctrl) begin
      if (addr_low[1]) io_rdata = {7'h00, flag_bit, debounced[23:16]};
      else             io_rdata = debounced[15:0];
    end
  end

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
- Downstream peripheral stage of the memory/IO steering block.
- Consumes its LED and switch chip selects, write data and address.
- Owns the board's 24 LEDs (registered, written on store) and 24 DIP switches (synchronised, debounced).
- Returns 16-bit read data to the steering block for load instructions.

Parameters:
- DEBOUNCE_CYCLES, 16'd20000, consecutive identical synchronised samples required before the debounced switch value updates; legal range 1..65535.
- SW_WIDTH, 24, number of switches and LEDs; fixed at 24 for this board, not to be varied.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- io_read  input  1  load to IO space this cycle.
- io_write  input  1  store to IO space this cycle.
- led_ctrl  input  1  LED chip select, active high.
- switch_ctrl  input  1  switch chip select, active high.
- addr_low  input  2  byte-address bits [1:0]; bit1 selects half, bit0 ignored.
- io_wdata  input  32  store data; only [15:0] used.
- switch_in  input  24  raw asynchronous switch pins.
- io_rdata  output  16  load data to the steering block.
- led_out  output  24  LED drive, registered.

Behaviour:
- Reset (async assert, sync release): led_out=0, both sync stages=0, candidate=0, debounce counter=0, debounced value=0. io_rdata is therefore 0 while reset is held.
- LED write: at a rising edge with io_write&led_ctrl:
  - addr_low[1]=0: led_out[15:0] <= io_wdata[15:0].
  - addr_low[1]=1: led_out[23:16] <= io_wdata[7:0].
  - The other half holds. Visible one cycle after the edge.
- No write when either io_write or led_ctrl is low. io_read has no effect on led_out.
- Synchroniser: two-flop chain on switch_in; output s.
- Debounce, every edge:
  - s != candidate: candidate <= s, counter <= 0.
  - else counter == DEBOUNCE_CYCLES-1: debounced <= candidate; counter holds (saturates).
  - else: counter <= counter+1.
- Debounce latency: a raw change held steady appears in debounced exactly DEBOUNCE_CYCLES+3 edges after the change is first sampled (2 sync, 1 candidate load, N count).
- A glitch shorter than DEBOUNCE_CYCLES consecutive samples never reaches debounced.
- A bounce during counting restarts the count from 0.
- Read path (combinational):
  - io_read&switch_ctrl, addr_low[1]=0: io_rdata = debounced[15:0].
  - io_read&switch_ctrl, addr_low[1]=1: io_rdata = {8'h00, debounced[23:16]}.
  - otherwise: io_rdata = 16'h0000.
- Simultaneous io_read and io_write in one cycle: both performed independently; the read returns the switches, never the LEDs.
- Reset mid-debounce: count discarded; after release the counter restarts from 0 and the full latency applies again.

Optional Feature:
- Macro: BOARD_IO_CHANGE_FLAG_EN.
- When defined:
  - A sticky 1-bit change flag sets on any edge where debounced changes value.
  - A read with switch_ctrl, io_read and addr_low[1]=1 returns {7'h00, flag, debounced[23:16]}.
  - The flag clears on the edge ending that read. If a set and a clear land on the same edge, set wins.
  - Reset clears the flag.
- When undefined: no flag register exists, and bit 8 of the high-half read is 0.

Test Plan:
- Reset: hold reset with switch_in=24'hFFFFFF, drive a read -> io_rdata=0 and led_out=0. Assert reset asynchronously mid-cycle -> led_out clears before the next edge.
- LED halves: store io_wdata=32'h0000A5C3 to addr_low=0 -> led_out=24'h00A5C3. Store 32'h0000007E to addr_low=2'b10 -> led_out=24'h7EA5C3. Store with led_ctrl=0 -> unchanged.
- Debounce latency (DEBOUNCE_CYCLES=4): switch_in 0->24'h12ABCD, held -> low-half read = 16'hABCD exactly at edge 7 after the change and not at edge 6. High-half read = 16'h0012.
- Glitch rejection (DEBOUNCE_CYCLES=4): pulse switch_in=24'h000001 for 3 cycles then back to 0 -> reads stay 16'h0000 throughout.
- Bounce restart (DEBOUNCE_CYCLES=4): toggle bit0 at edges 0, 2, 3, then hold -> update occurs 7 edges after the last toggle.
- With BOARD_IO_CHANGE_FLAG_EN: a debounced change, then a high-half read -> bit8=1. The next high-half read -> bit8=0. Change and read on the same edge -> bit8 remains 1 afterwards.
